fb_pixel_plotter: RTL
=====================

# fb_pixel_plotter

Hardware pixel plot unit for the SM memory path. It takes (x, y, colour, op) pixel requests over a valid/ready handshake and clips them against the framebuffer bounds. Each surviving pixel becomes a read-modify-write on a 32-bit word memory port. One dirty word is held so that runs of pixels landing in the same word cost a single read and a single write. It generalises the software plot loop (shift, mask, LDR/OR/STR) to configurable resolution, bits per pixel and raster op.

## Interface

Parameters:
- FB_WIDTH, 64, pixels per row; FB_WIDTH*BPP must be a multiple of 32
- FB_HEIGHT, 64, rows
- BPP, 1, bits per pixel; legal values 1, 2, 4, 8, 16, 32
- COORD_W, 16, signed coordinate width

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset; asynchronous, active-low
- cfg_fb_base  in  32  framebuffer byte base address; word aligned; sampled at pixel accept
- pix_valid  in  1  pixel request valid
- pix_ready  out  1  pixel request accepted this cycle when high with pix_valid
- pix_x, pix_y  in  COORD_W  signed pixel coordinates
- pix_color  in  BPP  pixel value
- pix_op  in  2  raster op: 00 OR, 01 REPLACE, 10 XOR, 11 CLEAR (AND-NOT)
- flush  in  1  write back the held word and invalidate it
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write, 0 = read
- mem_req_addr  out  32  byte address, word aligned
- mem_req_wdata  out  32  write data
- mem_rsp_valid  in  1  read data valid; responses arrive in order
- mem_rsp_rdata  in  32  read data
- busy  out  1  state is not IDLE
- clip_count  out  16  saturating count of clipped pixels

## Operation

**Addressing**
- Linear index L = y*FB_WIDTH + x, computed unsigned after clipping.
- Word address = cfg_fb_base + ((L*BPP) >> 5)*4.
- Bit offset = (L*BPP) & 31. The field is LSB-first, so pixel x=0 occupies bit 0.
- For BPP=1, FB_WIDTH=64 this gives base + y*8 + (x>>5)*4, bit x&31.

**Clipping**
- A pixel with x<0, x>=FB_WIDTH, y<0 or y>=FB_HEIGHT is accepted and dropped.
- clip_count increments, saturating at 0xFFFF. Hold state and memory are untouched.

**Merge**
- Field f = pix_color at the bit offset; mask m = BPP ones at the bit offset.
- OR: w|f. REPLACE: (w&~m)|f. XOR: w^f. CLEAR: w&~f.

**State machine**
- IDLE: no word held; pix_ready=1.
  - Unclipped pixel accepted → READ.
- HOLD: word held (hold_addr, hold_data); pix_ready = !flush.
  - Pixel accepted with a matching address → merge into hold_data, stay in HOLD.
  - Pixel accepted with a non-matching address → WRITEBACK, capturing the pending pixel.
  - flush → WRITEBACK with no pending pixel.
- WRITEBACK: write of hold_data to hold_addr.
  - On handshake: if a pixel is pending → READ, otherwise → IDLE.
- READ: read request for the pending pixel's word.
  - On handshake → RDWAIT.
- RDWAIT: wait for mem_rsp_valid, then merge into rdata → HOLD.
- pix_ready=0 in WRITEBACK, READ and RDWAIT.
- flush in IDLE, or during a transaction, is a no-op. A flush issued mid-transaction is not remembered, so the requester re-asserts it once in HOLD.
- At most one memory request is outstanding.
- The held word is invisible to memory until written back. Consumers of the framebuffer must flush and wait for !busy first.

## Timing

- Reset values: pix_ready=1, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0, busy=0, clip_count=0, hold invalid, state IDLE.
- Reset mid-operation discards the held word and any pending pixel. A response arriving after reset is ignored.
- Hit in HOLD: hold_data is updated at the next edge, and the next pixel can be accepted that same edge (1 pixel/cycle).
- Clipped pixel: 1 pixel/cycle in IDLE and HOLD.
- Miss from IDLE: request valid the cycle after accept. Merge completes the edge the response is seen; HOLD follows.
- Miss from HOLD: the write is issued first, and the read becomes valid the cycle after the write handshake.
- mem_req_addr, mem_req_we and mem_req_wdata hold stable while mem_req_valid=1 && !mem_req_ready.
- mem_req_valid deasserts the cycle after the handshake.

## Test plan

- **Single pixel.** BPP=1, base 0x2000, memory zero; plot (3,2) OR, then flush.
  - Read 0x2010, then write 0x2010 data 0x00000008.
  - busy falls after the write.
- **Coalescing.** Plot (0..31, 0) OR back-to-back, then flush.
  - Exactly one read and one write at 0x2000, data 0xFFFFFFFF.
  - 32 consecutive pix_ready cycles after the first fill.
- **Eviction order.** Plot (0,0), then (40,0).
  - Write 0x2000 (0x1) occurs before read 0x2004.
  - Flush writes 0x2004 with bit 8 set.
- **Clipping.** Plot (-1,5), (64,0), (0,64).
  - Each accepted in one cycle.
  - clip_count=3 and no mem_req_valid.
- **Raster ops.** BPP=4, rdata 0xFFFFFFFF.
  - REPLACE x=3 colour 0xA gives 0xFFFFAFFF.
  - Then XOR x=3 colour 0xF gives 0xFFFF5FFF.
  - Then CLEAR x=0 colour 0x3 gives 0xFFFF5FFC.
- **Backpressure and reset.** Hold mem_req_ready low 5 cycles: address and data stay stable. Then drop rst_n during RDWAIT.
  - All outputs return to reset values.
  - A late mem_rsp_valid causes no state change.

Source files
------------

// File: rtl/fb_pixel_plotter_if.sv
// Pixel request, flush and memory port bundle for fb_pixel_plotter.
// The slave modport is the plotter; the master side feeds pixels and serves memory.
interface fb_pixel_plotter_if #(
  parameter int COORD_W = 16,
  parameter int BPP     = 1
);
  logic [31:0]        cfg_fb_base;
  logic               pix_valid;
  logic               pix_ready;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [BPP-1:0]     pix_color;
  logic [1:0]         pix_op;
  logic               flush;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic               mem_req_we;
  logic [31:0]        mem_req_addr;
  logic [31:0]        mem_req_wdata;
  logic               mem_rsp_valid;
  logic [31:0]        mem_rsp_rdata;
  logic               busy;
  logic [15:0]        clip_count;

  modport master (
    output cfg_fb_base, pix_valid, pix_x, pix_y, pix_color, pix_op, flush,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  pix_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, busy, clip_count
  );

  modport slave (
    input  cfg_fb_base, pix_valid, pix_x, pix_y, pix_color, pix_op, flush,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output pix_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, busy, clip_count
  );
endinterface

// File: rtl/fb_pixel_plotter.sv
// Clipping pixel plotter: read-modify-write of 32-bit framebuffer words,
// holding one dirty word so runs of pixels in the same word share one read and one write.
module fb_pixel_plotter #(
  parameter int FB_WIDTH  = 64,
  parameter int FB_HEIGHT = 64,
  parameter int BPP       = 1,
  parameter int COORD_W   = 16
) (
  input logic               clk,
  input logic               rst_n,
  fb_pixel_plotter_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StHold, StWriteback, StRead, StRdwait} state_e;

  state_e         state_q;
  logic [31:0]    hold_addr_q, hold_data_q;
  logic           pend_v_q;
  logic [31:0]    pend_addr_q;
  logic [4:0]     pend_off_q;
  logic [BPP-1:0] pend_color_q;
  logic [1:0]     pend_op_q;
  logic           req_valid_q, req_we_q;
  logic [31:0]    req_addr_q, req_wdata_q;
  logic [15:0]    clip_count_q;

  int          x_s, y_s;
  logic        clipped;
  logic [31:0] lin, bitpos, pix_addr;
  logic [4:0]  pix_off;
  logic        pix_ready;
  logic        accept;

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [BPP-1:0] c,
                                        input logic [4:0] off, input logic [1:0] op);
    logic [31:0] f, m;
    f = 32'(c) << off;
    m = 32'({BPP{1'b1}}) << off;
    case (op)
      2'b00:   merge = w | f;
      2'b01:   merge = (w & ~m) | f;
      2'b10:   merge = w ^ f;
      default: merge = w & ~f;
    endcase
  endfunction

  // Address is only meaningful for unclipped pixels, where L is non-negative.
  always_comb begin
    x_s      = int'($signed(bus.pix_x[COORD_W-1:0]));
    y_s      = int'($signed(bus.pix_y[COORD_W-1:0]));
    clipped  = (x_s < 0) || (x_s >= FB_WIDTH) || (y_s < 0) || (y_s >= FB_HEIGHT);
    lin      = unsigned'(y_s * FB_WIDTH + x_s);
    bitpos   = lin * unsigned'(BPP);
    pix_addr = bus.cfg_fb_base + ((bitpos >> 5) << 2);
    pix_off  = bitpos[4:0];
  end

  assign pix_ready = (state_q == StIdle) || ((state_q == StHold) && !bus.flush);
  assign accept    = bus.pix_valid && pix_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      pend_v_q     <= 1'b0;
      pend_addr_q  <= '0;
      pend_off_q   <= '0;
      pend_color_q <= '0;
      pend_op_q    <= '0;
      req_valid_q  <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      clip_count_q <= '0;
    end else begin
      if (accept && clipped && (clip_count_q != 16'hFFFF)) begin
        clip_count_q <= clip_count_q + 16'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (accept && !clipped) begin
            pend_addr_q  <= pix_addr;
            pend_off_q   <= pix_off;
            pend_color_q <= bus.pix_color;
            pend_op_q    <= bus.pix_op;
            req_valid_q  <= 1'b1;
            req_we_q     <= 1'b0;
            req_addr_q   <= pix_addr;
            state_q      <= StRead;
          end
        end
        StHold: begin
          if (bus.flush) begin
            pend_v_q    <= 1'b0;
            req_valid_q <= 1'b1;
            req_we_q    <= 1'b1;
            req_addr_q  <= hold_addr_q;
            req_wdata_q <= hold_data_q;
            state_q     <= StWriteback;
          end else if (accept && !clipped) begin
            if (pix_addr == hold_addr_q) begin
              hold_data_q <= merge(hold_data_q, bus.pix_color, pix_off, bus.pix_op);
            end else begin
              pend_v_q     <= 1'b1;
              pend_addr_q  <= pix_addr;
              pend_off_q   <= pix_off;
              pend_color_q <= bus.pix_color;
              pend_op_q    <= bus.pix_op;
              req_valid_q  <= 1'b1;
              req_we_q     <= 1'b1;
              req_addr_q   <= hold_addr_q;
              req_wdata_q  <= hold_data_q;
              state_q      <= StWriteback;
            end
          end
        end
        StWriteback: begin
          if (bus.mem_req_ready) begin
            // A pending pixel turns the request straight into its read.
            if (pend_v_q) begin
              pend_v_q   <= 1'b0;
              req_we_q   <= 1'b0;
              req_addr_q <= pend_addr_q;
              state_q    <= StRead;
            end else begin
              req_valid_q <= 1'b0;
              state_q     <= StIdle;
            end
          end
        end
        StRead: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= StRdwait;
          end
        end
        StRdwait: begin
          if (bus.mem_rsp_valid) begin
            hold_addr_q <= pend_addr_q;
            hold_data_q <= merge(bus.mem_rsp_rdata, pend_color_q, pend_off_q, pend_op_q);
            state_q     <= StHold;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pix_ready     = pix_ready;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_we    = req_we_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.busy          = (state_q != StIdle);
  assign bus.clip_count    = clip_count_q;

endmodule
